// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard / flush controller
//
// Purpose
//   Arbitrates stall requests from the ID, EX and MEM stages and flush
//   requests from the exception unit. It produces the per-stage freeze
//   vector, the flush strobe and the restart PC.
//
//   The freeze vector, flush strobe and restart PC are combinational from
//   the inputs, with zero-cycle latency. A small FSM, a consecutive-stall
//   counter and a sticky watchdog flag are registered for observation.
//   The watchdog never feeds back into the stall vector.
//
// Parameters
//   STALL_LIMIT    consecutive-stall count at which stall_timeout sets
//
// Ports
//   clk            pipeline clock, rising edge
//   rst            synchronous, active-high reset; also masks the
//                  combinational outputs while high
//   stallreq_id    ID stage stall request (load-use interlock)
//   stallreq_ex    EX stage stall request (multi-cycle unit busy)
//   stallreq_mem   MEM stage stall request (data memory not ready)
//   flush_req      flush request from exception / eret
//   flush_pc       restart address accompanying flush_req
//   stall[5:0]     freeze vector: PC, IF/ID, ID/EX, EX/MEM, MEM/WB;
//                  bit 5 is reserved and is always 0
//   flush          clears all pipeline registers this cycle
//   new_pc         PC load value, valid while flush=1, otherwise 0
//   state_o        FSM state: 00 RUN, 01 STALL, 10 FLUSH
//   stall_cnt      saturating consecutive-stall cycle count
//   stall_timeout  sticky watchdog flag, cleared only by rst
//
// Optional feature (macro PIPE_CTRL_PERF_EN)
//   Adds the following outputs:
//   perf_stall_cycles  count of edges with stall!=0, wraps modulo 2^32
//   perf_flush_count   count of edges with flush=1,  wraps modulo 2^32
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter logic [7:0] STALL_LIMIT = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [1:0]  state_o,
  output logic [7:0]  stall_cnt,
  output logic        stall_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  // Freeze patterns. A stalling stage freezes itself and every stage
  // upstream of it, so the bubble enters just below the requester.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  state_t     state;
  logic [7:0] cnt_inc;
  logic       stalling;

  // -------------------------------------------------------------------------
  // Combinational arbitration: flush > mem > ex > id. rst masks all of it.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first, so no path through the if
    // chain leaves a signal unassigned and no latch is inferred.
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (!rst) begin
      if (flush_req) begin
        flush  = 1'b1;
        new_pc = flush_pc;
      end else if (stallreq_mem) begin
        stall = STALL_MEM;
      end else if (stallreq_ex) begin
        stall = STALL_EX;
      end else if (stallreq_id) begin
        stall = STALL_ID;
      end
    end
  end

  assign stalling = (stall != STALL_NONE);

  // Saturating increment: the counter sticks at 8'hFF.
  assign cnt_inc = (stall_cnt == 8'hFF) ? 8'hFF : stall_cnt + 8'd1;

  assign state_o = state;

  // -------------------------------------------------------------------------
  // Registered state. The FSM, the stall counter and the watchdog live in one
  // block. All of them follow the arbitrated outputs, so an edge that
  // flushes also clears the counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // right-hand side then sees the pre-edge value, whatever the statement
    // order.
    if (rst) begin
      state         <= ST_RUN;
      stall_cnt     <= 8'h00;
      stall_timeout <= 1'b0;
    end else begin
      if (flush) begin
        state <= ST_FLUSH;
      end else if (stalling) begin
        state <= ST_STALL;
      end else begin
        state <= ST_RUN;
      end

      if (stalling) begin
        stall_cnt <= cnt_inc;
        // The flag sets on the edge where the count becomes STALL_LIMIT.
        if (cnt_inc == STALL_LIMIT) begin
          stall_timeout <= 1'b1;
        end
      end else begin
        stall_cnt <= 8'h00;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // -------------------------------------------------------------------------
  // Free-running performance counters. They wrap naturally at 2^32.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= 32'h0;
      perf_flush_count  <= 32'h0;
    end else begin
      if (stalling) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (flush) begin
        perf_flush_count <= perf_flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl
//
// Inputs change 1 time unit after a rising edge. Combinational outputs are
// sampled 1 unit after that. Registered outputs are sampled 1 unit after
// the edge that updates them. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  state_o;
  logic [7:0]  stall_cnt;
  logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_LIMIT(8'd200)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .flush_req     (flush_req),
    .flush_pc      (flush_pc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .state_o       (state_o),
    .stall_cnt     (stall_cnt),
    .stall_timeout (stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, leaving 1 unit of settle time.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a request pattern and let the combinational outputs settle.
  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic fr, input logic [31:0] pc);
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    flush_req    = fr;
    flush_pc     = pc;
    #1;
  endtask

  initial begin
    // Reset with every request asserted: rst must mask all of them.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("rst_stall_comb", {26'd0, stall}, 32'h0);
    check("rst_flush_comb", {31'd0, flush}, 32'h0);
    check("rst_newpc_comb", new_pc, 32'h0);
    tick();
    tick();
    check("rst_state", {30'd0, state_o}, 32'h0);
    check("rst_cnt", {24'd0, stall_cnt}, 32'h0);
    check("rst_timeout", {31'd0, stall_timeout}, 32'h0);

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("idle_stall", {26'd0, stall}, 32'h0);
    check("idle_newpc", new_pc, 32'h0);

    // Priority among the stall requests, all in the same cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("prio_id_ex", {26'd0, stall}, 32'h0000_000F);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("prio_all", {26'd0, stall}, 32'h0000_001F);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234);
    check("prio_id", {26'd0, stall}, 32'h0000_0007);
    check("stall_no_flush", {31'd0, flush}, 32'h0);
    check("stall_newpc_zero", new_pc, 32'h0);
    tick();
    check("state_stall", {30'd0, state_o}, 32'h1);
    check("cnt_one", {24'd0, stall_cnt}, 32'h1);

    // A flush overrides a simultaneous memory stall.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0180);
    check("flush_flag", {31'd0, flush}, 32'h1);
    check("flush_newpc", new_pc, 32'h0000_0180);
    check("flush_stall", {26'd0, stall}, 32'h0);
    tick();
    check("flush_state", {30'd0, state_o}, 32'h2);
    check("flush_cnt", {24'd0, stall_cnt}, 32'h0);
    tick();
    check("flush_b2b_state", {30'd0, state_o}, 32'h2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0180);
    check("post_flush_newpc", new_pc, 32'h0);
    tick();
    check("run_after_flush", {30'd0, state_o}, 32'h0);

    // Watchdog: hold EX for 200 edges, then keep going into saturation.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 199; i++) tick();
    check("wd_cnt_199", {24'd0, stall_cnt}, 32'd199);
    check("wd_not_yet", {31'd0, stall_timeout}, 32'h0);
    tick();
    check("wd_cnt_200", {24'd0, stall_cnt}, 32'd200);
    check("wd_fire", {31'd0, stall_timeout}, 32'h1);
    check("wd_no_effect", {26'd0, stall}, 32'h0000_000F);
    for (int i = 0; i < 55; i++) tick();
    check("wd_cnt_255", {24'd0, stall_cnt}, 32'd255);
    tick();
    check("wd_cnt_sat", {24'd0, stall_cnt}, 32'd255);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("wd_cnt_clear", {24'd0, stall_cnt}, 32'h0);
    check("wd_sticky", {31'd0, stall_timeout}, 32'h1);
    check("wd_state_run", {30'd0, state_o}, 32'h0);

    // Reset in the middle of a 10-cycle stall abandons it completely.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    check("mid_cnt_10", {24'd0, stall_cnt}, 32'd10);
    check("mid_state_stall", {30'd0, state_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall_comb", {26'd0, stall}, 32'h0);
    tick();
    check("mid_rst_state", {30'd0, state_o}, 32'h0);
    check("mid_rst_cnt", {24'd0, stall_cnt}, 32'h0);
    check("mid_rst_timeout", {31'd0, stall_timeout}, 32'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("post_rst_stall", {26'd0, stall}, 32'h0);
    tick();
    check("post_rst_state", {30'd0, state_o}, 32'h0);
    check("post_rst_cnt", {24'd0, stall_cnt}, 32'h0);

`ifdef PIPE_CTRL_PERF_EN
    // Fresh reset, then 3 stalls, 1 idle cycle and 2 flushes.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_rst_stall", perf_stall_cycles, 32'h0);
    check("perf_rst_flush", perf_flush_count, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 2; i++) tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("perf_stall_3", perf_stall_cycles, 32'd3);
    check("perf_flush_2", perf_flush_count, 32'd2);
    // Preload the stall counter to its top value, then one more stall.
    force dut.perf_stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.perf_stall_cycles;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check("perf_wrap", perf_stall_cycles, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the run time so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "time limit exceeded");
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STALL_LIMIT, default 8'd200, is the consecutive-stall cycle count at which the watchdog fires.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stallreq_id  input  1  ID stage requests a stall (load-use interlock).
REQ-005 stallreq_ex  input  1  EX stage requests a stall (multi-cycle mul/div/madd busy).
REQ-006 stallreq_mem  input  1  MEM stage requests a stall (data memory not ready).
REQ-007 flush_req  input  1  exception/eret requests a pipeline flush.
REQ-008 flush_pc  input  32  restart address accompanying flush_req.
REQ-009 stall  output  6  freeze vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
REQ-010 flush  output  1  clears all pipeline registers this cycle.
REQ-011 new_pc  output  32  PC load value, valid while flush=1.
REQ-012 state_o  output  2  current FSM state: 00 RUN, 01 STALL, 10 FLUSH.
REQ-013 stall_cnt  output  8  current consecutive-stall cycle count, saturating.
REQ-014 stall_timeout  output  1  sticky watchdog flag.

Function
REQ-015 stall, flush and new_pc shall be combinational from the inputs, with zero-cycle latency.
REQ-016 Priority shall be flush_req > stallreq_mem > stallreq_ex > stallreq_id.
REQ-017 flush_req=1 shall drive flush=1, new_pc=flush_pc and stall=6'b000000, regardless of the stall requests.
REQ-018 stallreq_mem shall drive stall=6'b011111; stallreq_ex shall drive 6'b001111; stallreq_id shall drive 6'b000111.
REQ-019 With no requests, the block shall drive stall=0, flush=0 and new_pc=32'h0.
REQ-020 FSM next state on each edge: flush_req -> FLUSH; else any stallreq -> STALL; else RUN.
REQ-021 From FLUSH, the FSM shall follow REQ-020 normally; back-to-back flush_req shall keep it in FLUSH.
REQ-022 stall_cnt shall increment by 1 on each edge where stall!=0, saturating at 8'hFF.
REQ-023 stall_cnt shall clear to 0 on any edge where stall==0, including flush cycles.
REQ-024 stall_timeout shall set on the edge where stall_cnt would reach STALL_LIMIT, and shall hold until rst.
REQ-025 The watchdog shall have no effect on the stall vector; it is observation only.
REQ-026 Simultaneous flush_req and any stallreq: flush wins, stall=0, stall_cnt clears, FSM goes to FLUSH.

Reset
REQ-027 rst=1 shall force stall=0, flush=0, new_pc=0 combinationally, overriding all inputs.
REQ-028 At the next edge with rst=1: state=RUN, stall_cnt=0, stall_timeout=0, and all perf counters 0.
REQ-029 Assertion of rst mid-stall or mid-flush shall abandon the operation with no residual state.

Configuration
REQ-030 With macro PIPE_CTRL_PERF_EN defined, the block shall add outputs perf_stall_cycles (32) and perf_flush_count (32).
REQ-031 perf_stall_cycles shall increment on each edge with stall!=0; perf_flush_count shall increment on each edge with flush=1.
REQ-032 Both perf counters shall wrap modulo 2^32 and shall reset to 0 on rst.
REQ-033 Without PIPE_CTRL_PERF_EN, the perf ports and perf counters shall not exist, and all other behaviour is identical.

Verification
REQ-034 Reset check: rst=1 for 2 cycles with all requests high -> stall=0, flush=0, state_o=00, stall_cnt=0, stall_timeout=0.
REQ-035 Priority check: stallreq_id=stallreq_ex=1 -> stall=6'b001111; then add stallreq_mem=1 -> stall=6'b011111 in the same cycle.
REQ-036 Flush override: flush_req=1, flush_pc=32'h0000_0180, stallreq_mem=1 -> flush=1, new_pc=32'h180, stall=0; next cycle state_o=10, stall_cnt=0.
REQ-037 Watchdog: stallreq_ex held for 200 cycles -> stall_timeout rises on the 200th edge; stall_cnt saturates at 255; request released -> stall_cnt=0 while stall_timeout remains 1.
REQ-038 Perf counters (PIPE_CTRL_PERF_EN defined): 3 stall cycles, 1 idle, 2 flushes -> perf_stall_cycles=3, perf_flush_count=2; preload counter to 32'hFFFF_FFFF plus one stall -> 0.
REQ-039 Reset mid-operation: rst asserted during a 10-cycle stall -> next edge state_o=00 and stall_cnt=0; after rst deasserts with no requests -> stall=0.
